// File: rtl/slave_fifo_pkg.sv
// ----------------------------------------------------------------------------
// slave_fifo_pkg: state encodings and bus constants shared by the FX3 slave-FIFO
// stream-IN writer and stream-OUT reader.                              Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package slave_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Flags arrive already registered and active-high; strobes are active-low.
  localparam logic FLAG_ACTIVE = 1'b1;
  localparam logic STROBE_ON   = 1'b0;
  localparam logic STROBE_OFF  = 1'b1;

  typedef enum logic [1:0] {
    SO_IDLE       = 2'd0,
    SO_WAIT_FLAGD = 2'd1,
    SO_READ       = 2'd2,
    SO_DRAIN      = 2'd3
  } stream_out_state_e;

  typedef enum logic [1:0] {
    SI_IDLE       = 2'd0,
    SI_WAIT_FLAGB = 2'd1,
    SI_WRITE      = 2'd2,
    SI_WRITE_WAIT = 2'd3
  } stream_in_state_e;

endpackage

`default_nettype wire

// File: rtl/slave_fifo_stream_out_if.sv
// ----------------------------------------------------------------------------
// slave_fifo_stream_out_if: FX3 read-side pins plus the downstream valid/ready
// stream of the stream-OUT reader.                                     Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface slave_fifo_stream_out_if
  import slave_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  stream_out_mode_selected;
  logic                  flagc_d;
  logic                  flagd_d;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  slrd_streamOUT_;
  logic                  sloe_streamOUT_;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  check_err;
  logic [15:0]           err_count;

  modport slave (
    input  stream_out_mode_selected, flagc_d, flagd_d, fifo_data_in, data_out_ready,
    output slrd_streamOUT_, sloe_streamOUT_, data_out, data_out_valid, check_err, err_count
  );

  modport master (
    output stream_out_mode_selected, flagc_d, flagd_d, fifo_data_in, data_out_ready,
    input  slrd_streamOUT_, sloe_streamOUT_, data_out, data_out_valid, check_err, err_count
  );

endinterface

`default_nettype wire

// File: rtl/slave_fifo_stream_out_skid_fifo.sv
// ----------------------------------------------------------------------------
// stream_out_skid_fifo: first-word fall-through synchronous FIFO with occupancy
// output; DEPTH must be a power of two so the pointers wrap naturally. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_out_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full buffer is only honoured when a pop frees a slot.
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/slave_fifo_stream_out.sv
// ----------------------------------------------------------------------------
// slave_fifo_stream_out: FX3 stream-OUT reader feeding a valid/ready stream via
// a credit-managed skid buffer. Pattern checker: SLAVE_FIFO_STREAM_OUT_CHECK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slave_fifo_stream_out
  import slave_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                   clk_100,
  input  logic                   reset_,
  slave_fifo_stream_out_if.slave bus
);

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;
  localparam int DRN_W = $clog2(RD_LATENCY + 2);

  stream_out_state_e     state_q, state_d;
  logic [DRN_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [RD_LATENCY-1:0] rd_hist_q, rd_hist_d;
  logic                  slrd_q, slrd_d;
  logic                  sloe_q, sloe_d;
  logic                  rd_issue;
  logic                  capture;
  logic                  pop;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W:0]        inflight;
  logic                  credit;
  logic                  mode;

  assign mode    = bus.stream_out_mode_selected;
  assign capture = rd_hist_q[RD_LATENCY-1];
  assign pop     = bus.data_out_valid && bus.data_out_ready;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state_q     <= SO_IDLE;
      drain_cnt_q <= '0;
      rd_hist_q   <= '0;
      slrd_q      <= STROBE_OFF;
      sloe_q      <= STROBE_OFF;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      rd_hist_q   <= rd_hist_d;
      slrd_q      <= slrd_d;
      sloe_q      <= sloe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      SO_IDLE: begin
        if (mode && (bus.flagc_d == FLAG_ACTIVE)) state_d = SO_WAIT_FLAGD;
      end
      SO_WAIT_FLAGD: begin
        if (!mode) begin
          state_d = SO_IDLE;
        end else if (bus.flagd_d == FLAG_ACTIVE) begin
          state_d = SO_READ;
        end
      end
      SO_READ: begin
        if (!mode || (bus.flagd_d != FLAG_ACTIVE)) begin
          state_d     = SO_DRAIN;
          drain_cnt_d = '0;
        end
      end
      SO_DRAIN: begin
        if (drain_cnt_q == DRN_W'(RD_LATENCY)) begin
          state_d = SO_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      default: state_d = SO_IDLE;
    endcase
  end

  // Every strobe in the history window is a word that will land in the buffer,
  // so it must already own a slot when the strobe is issued.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (OCC_W+1)'(rd_hist_q[i]);
    end
  end

  assign credit = (({1'b0, occupancy} + inflight) < (OCC_W+1)'(SKID_DEPTH));

  always_comb begin
    rd_issue = (state_d == SO_READ) && (bus.flagd_d == FLAG_ACTIVE) && credit;
    slrd_d   = rd_issue ? STROBE_ON : STROBE_OFF;
    sloe_d   = (state_d != SO_IDLE) ? STROBE_ON : STROBE_OFF;
  end

  if (RD_LATENCY > 1) begin : g_hist_shift
    assign rd_hist_d = {rd_hist_q[RD_LATENCY-2:0], rd_issue};
  end else begin : g_hist_single
    assign rd_hist_d = rd_issue;
  end

  assign bus.slrd_streamOUT_ = slrd_q;
  assign bus.sloe_streamOUT_ = sloe_q;

  stream_out_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk_i   (clk_100),
    .rst_ni  (reset_),
    .push_i  (capture),
    .data_i  (bus.fifo_data_in),
    .pop_i   (pop),
    .data_o  (bus.data_out),
    .valid_o (bus.data_out_valid),
    .count_o (occupancy)
  );

`ifdef SLAVE_FIFO_STREAM_OUT_CHECK_EN
  logic [DATA_WIDTH-1:0] expect_q;
  logic [15:0]           err_count_q;
  logic                  check_err_q;

  // A capture takes priority over the mode-low clear so late in-flight words
  // are still compared against the running pattern.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      expect_q    <= '0;
      err_count_q <= '0;
      check_err_q <= 1'b0;
    end else if (capture) begin
      if (bus.fifo_data_in != expect_q) begin
        check_err_q <= 1'b1;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
      expect_q <= bus.fifo_data_in + DATA_WIDTH'(1);
    end else if (!mode) begin
      expect_q <= '0;
    end
  end

  assign bus.check_err = check_err_q;
  assign bus.err_count = err_count_q;
`else
  assign bus.check_err = 1'b0;
  assign bus.err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slave_fifo_stream_out.sv
// ----------------------------------------------------------------------------
// tb_slave_fifo_stream_out: randomized bench with an FX3 read model, an
// in-order scoreboard and a pattern-checker model.                     Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_slave_fifo_stream_out;

  localparam int DW    = 32;
  localparam int RDL   = 2;
  localparam int DEPTH = 4;
`ifdef SLAVE_FIFO_STREAM_OUT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk_100 = 1'b0;
  logic reset_  = 1'b1;
  always #5 clk_100 = ~clk_100;

  slave_fifo_stream_out_if #(.DATA_WIDTH(DW)) bus ();

  slave_fifo_stream_out #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (RDL),
    .SKID_DEPTH (DEPTH)
  ) dut (
    .clk_100 (clk_100),
    .reset_  (reset_),
    .bus     (bus)
  );

  typedef struct packed {
    logic          strobe;
    logic [DW-1:0] val;
  } beat_t;

  int            errors = 0;
  int            checks = 0;
  beat_t         pipe_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] fx3_cnt;
  bit            skip50;
  int            issued, popped, max_buf;
  logic [DW-1:0] chk_exp;
  int            chk_errs;
  bit            chk_flag;
  bit            s_strobe, s_sloe_low, s_valid, s_pop;
  logic [DW-1:0] s_pop_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, score pops, run the FX3 model.
  task automatic tick();
    beat_t b;
    bit    present;
    @(negedge clk_100);
    s_strobe   = (bus.slrd_streamOUT_ == 1'b0);
    s_sloe_low = (bus.sloe_streamOUT_ == 1'b0);
    s_valid    = bus.data_out_valid;
    s_pop      = bus.data_out_valid && bus.data_out_ready;
    if (s_pop) begin
      s_pop_val = bus.data_out;
      if (sb_q.size() == 0) check_val("pop_without_word", sb_q.size(), 1);
      else check_val("pop_data", bus.data_out, sb_q.pop_front());
      popped++;
    end
    b.strobe = s_strobe;
    b.val    = $urandom;
    if (s_strobe) begin
      if (skip50 && fx3_cnt == 50) fx3_cnt++;
      b.val = fx3_cnt;
      fx3_cnt++;
      issued++;
    end
    pipe_q.push_back(b);
    present = 1'b0;
    if (pipe_q.size() > RDL - 1) begin
      b = pipe_q.pop_front();
      bus.fifo_data_in = b.val;
      present = b.strobe;
    end
    if (reset_) begin
      if (present) begin
        sb_q.push_back(b.val);
        if (b.val != chk_exp) begin
          if (chk_errs < 65535) chk_errs++;
          chk_flag = 1'b1;
        end
        chk_exp = b.val + 1;
      end else if (!bus.stream_out_mode_selected) begin
        chk_exp = '0;
      end
    end
    if (sb_q.size() > max_buf) max_buf = sb_q.size();
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset();
    #2 reset_ = 1'b0;
    #1;
    check_val("async_rst_slrd", bus.slrd_streamOUT_, 1);
    check_val("async_rst_sloe", bus.sloe_streamOUT_, 1);
    check_val("async_rst_valid", bus.data_out_valid, 0);
    pipe_q.delete();
    sb_q.delete();
    chk_exp  = '0;
    chk_errs = 0;
    chk_flag = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  task automatic check_errs(input string tag);
    check_val({tag, "_err_count"}, bus.err_count, CHECK_EN ? chk_errs : 0);
    check_val({tag, "_check_err"}, bus.check_err, CHECK_EN ? chk_flag : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, guard, gaps, cnt, strobes;
    bit  seen, prev;
    logic [DW-1:0] next_word;

    bus.stream_out_mode_selected = 1'b0;
    bus.flagc_d        = 1'b0;
    bus.flagd_d        = 1'b0;
    bus.fifo_data_in   = '0;
    bus.data_out_ready = 1'b0;
    fx3_cnt = '0; skip50 = 1'b0; issued = 0; popped = 0; max_buf = 0;
    chk_exp = '0; chk_errs = 0; chk_flag = 1'b0;

    #1 reset_ = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    check_val("rst_slrd", bus.slrd_streamOUT_, 1);
    check_val("rst_sloe", bus.sloe_streamOUT_, 1);
    check_val("rst_valid", bus.data_out_valid, 0);
    check_val("rst_data", bus.data_out, 0);
    check_errs("rst");
    reset_ = 1'b1;
    tick();
    tick();

    // Run 1: full-rate stream, stall, random backpressure, mode drop.
    bus.stream_out_mode_selected = 1'b1;
    bus.flagc_d = 1'b1;
    bus.flagd_d = 1'b1;
    bus.data_out_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!s_strobe && n < 10);
    // The first sample falls in the cycle where mode rose, so edges = n-1.
    check_val("slrd_latency_cycles", n - 1, 2);

    gaps = 0; seen = 1'b0; guard = 0;
    while (popped < 100 && guard < 400) begin
      tick();
      guard++;
      if (s_valid) seen = 1'b1;
      else if (seen) gaps++;
    end
    check_val("run1_100_words_in_time", guard < 400, 1);
    check_val("run1_gaps", gaps, 0);
    check_errs("run1");

    bus.data_out_ready = 1'b0;
    max_buf = sb_q.size();
    repeat (20) tick();
    check_val("stall_max_buffered_ok", max_buf <= DEPTH, 1);
    check_val("stall_buffered", sb_q.size(), DEPTH);
    check_val("stall_slrd_high", s_strobe, 0);

    repeat (300) begin
      bus.data_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    bus.data_out_ready = 1'b1;
    prev = 1'b0; guard = 0;
    do begin prev = s_strobe; tick(); guard++; end while (!(s_strobe && prev) && guard < 50);
    check_val("two_in_flight_found", s_strobe && prev, 1);
    bus.stream_out_mode_selected = 1'b0;
    tick();
    strobes = 0;
    repeat (10) begin tick(); if (s_strobe) strobes++; end
    check_val("mode_drop_no_strobes", strobes, 0);
    check_val("mode_drop_all_delivered", popped, issued);
    check_val("mode_drop_sb_empty", sb_q.size(), 0);
    check_val("mode_drop_sloe_high", bus.sloe_streamOUT_, 1);

    // Run 2: flagd falls once word 37 has been strobed.
    do_reset();
    fx3_cnt = '0; issued = 0; popped = 0;
    bus.stream_out_mode_selected = 1'b1;
    bus.flagc_d = 1'b1;
    bus.flagd_d = 1'b1;
    guard = 0;
    while (issued < 38 && guard < 200) begin tick(); guard++; end
    check_val("run2_reached_word37", issued >= 38, 1);
    bus.flagd_d = 1'b0;
    bus.flagc_d = 1'b0;
    tick();
    cnt = 0; strobes = 0;
    repeat (8) begin
      tick();
      if (s_sloe_low) cnt++;
      if (s_strobe) strobes++;
    end
    check_val("drain_cycles", cnt, RDL + 1);
    check_val("drain_no_strobes", strobes, 0);
    check_val("drain_sloe_high", bus.sloe_streamOUT_, 1);
    check_val("drain_all_delivered", popped, issued);
    check_val("drain_sb_empty", sb_q.size(), 0);

    // Run 3: FX3 skips value 50, then reset mid-READ.
    do_reset();
    fx3_cnt = '0; issued = 0; popped = 0; skip50 = 1'b1;
    bus.flagc_d = 1'b1;
    bus.flagd_d = 1'b1;
    guard = 0;
    while (popped < 90 && guard < 1000) begin
      bus.data_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    check_val("run3_90_words_in_time", guard < 1000, 1);
    check_val("skip_model_errs", chk_errs, 1);
    check_errs("skip");

    bus.data_out_ready = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!s_strobe && guard < 20);
    do_reset();
    next_word = fx3_cnt;
    guard = 0;
    do begin tick(); guard++; end while (!s_pop && guard < 20);
    check_val("post_reset_first_pop_seen", s_pop, 1);
    check_val("post_reset_first_word", s_pop_val, next_word);
    repeat (40) tick();
    check_errs("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
